// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared types and constants for the two-requester RAM arbiter
package ram_arb_pkg;
    localparam int NUM_REQ    = 2;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_READ  = 2'd2
    } state_t;
endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - combinational 2-way round-robin picker
module rr_pick2
    import ram_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] valid,
    input  logic               last_grant,
    output logic               grant,
    output logic               any
);

    // On a tie the requester that did not win last time goes next.
    always_comb begin
        any   = |valid;
        grant = 1'b0;
        if (valid == 2'b11) begin
            grant = ~last_grant;
        end else begin
            grant = valid[1];
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - round-robin arbiter and access sequencer for the 8x8 single-port RAM
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0]            req_we,
    input  logic [2*ADDR_W-1:0]   req_addr,
    input  logic [2*DATA_W-1:0]   req_wdata,
    output logic [1:0]            rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata
);

    state_t state, state_nxt;
    logic   grant_q;
    logic   last_grant;
    logic   pick_grant;
    logic   pick_any;

    logic              take;
    logic              capture;
    logic [1:0]        pick_onehot;
    logic [1:0]        grant_onehot;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    rr_pick2 u_pick (
        .valid      (req_valid),
        .last_grant (last_grant),
        .grant      (pick_grant),
        .any        (pick_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // mem_we still holds the issued access type while in ISSUE.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  state_nxt = pick_any ? ST_ISSUE : ST_IDLE;
            ST_ISSUE: state_nxt = mem_we ? ST_IDLE : ST_READ;
            ST_READ:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        take         = (state == ST_IDLE) && pick_any;
        capture      = (state == ST_READ);
        pick_onehot  = pick_grant ? 2'b10 : 2'b01;
        grant_onehot = grant_q ? 2'b10 : 2'b01;
        sel_we       = pick_grant ? req_we[1] : req_we[0];
        sel_addr     = pick_grant ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
        sel_wdata    = pick_grant ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q    <= 1'b0;
            last_grant <= 1'b1;
            req_ready  <= '0;
            rsp_valid  <= '0;
            rsp_rdata  <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            req_ready <= '0;
            rsp_valid <= '0;
            mem_en    <= 1'b0;
            if (take) begin
                grant_q    <= pick_grant;
                last_grant <= pick_grant;
                req_ready  <= pick_onehot;
                mem_en     <= 1'b1;
                mem_we     <= sel_we;
                mem_addr   <= sel_addr;
                mem_wdata  <= sel_wdata;
            end
            if (capture) begin
                rsp_rdata <= mem_rdata;
                rsp_valid <= grant_onehot;
            end
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - directed self-checking bench for ram_arbiter
module tb_ram_arbiter;
    localparam int DW = 8;
    localparam int AW = 3;

    logic            clk;
    logic            rst;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [1:0]      req_we;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_wdata;
    logic [1:0]      rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            mem_en;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata;

    logic [DW-1:0] ram_q [8];
    int n_checks = 0;
    int n_fail   = 0;
    int en_b2b   = 0;
    int rdy_ovl  = 0;
    logic prev_en = 1'b0;

    ram_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 8x8 single-port RAM with registered read data.
    initial begin
        for (int i = 0; i < 8; i++) ram_q[i] = '0;
        mem_rdata = '0;
    end
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram_q[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram_q[mem_addr];
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_en && prev_en) en_b2b++;
            if (req_ready == 2'b11) rdy_ovl++;
        end
        prev_en = mem_en;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i] = 1'b1;
        req_we[i]    = we;
        if (i == 0) begin
            req_addr[AW-1:0]  = a;
            req_wdata[DW-1:0] = d;
        end else begin
            req_addr[2*AW-1:AW]  = a;
            req_wdata[2*DW-1:DW] = d;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        int g;
        rst = 1'b1; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        step();
        step();
        check("rst_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        rst = 1'b0;

        // r0 writes 32 to addr 3, r1 reads it back
        set_req(0, 1'b1, 3'd3, 8'd32);
        step();
        check("t1_ready", req_ready, 2'b01);
        check("t1_mem_en", mem_en, 1);
        check("t1_mem_we", mem_we, 1);
        check("t1_mem_addr", mem_addr, 3);
        check("t1_mem_wdata", mem_wdata, 32);
        req_valid[0] = 1'b0;
        step();
        check("t1_en_clear", mem_en, 0);
        set_req(1, 1'b0, 3'd3, 8'd0);
        step();
        check("t1_rd_ready", req_ready, 2'b10);
        check("t1_rd_we", mem_we, 0);
        req_valid[1] = 1'b0;
        step();
        check("t1_rd_early", rsp_valid, 0);
        step();
        check("t1_rsp_valid", rsp_valid, 2'b10);
        check("t1_rsp_rdata", rsp_rdata, 32);

        // simultaneous requests after reset: r0 first
        do_reset();
        set_req(0, 1'b1, 3'd4, 8'd44);
        set_req(1, 1'b0, 3'd4, 8'd0);
        step();
        check("t2_first", req_ready, 2'b01);
        req_valid[0] = 1'b0;
        step();
        check("t2_gap", req_ready, 0);
        step();
        check("t2_second", req_ready, 2'b10);
        check("t2_addr", mem_addr, 4);
        req_valid[1] = 1'b0;
        step();
        step();
        check("t2_rsp_valid", rsp_valid, 2'b10);
        check("t2_rsp_rdata", rsp_rdata, 44);

        // continuous contention, writes from both
        set_req(0, 1'b1, 3'd1, 8'h11);
        set_req(1, 1'b1, 3'd2, 8'h22);
        g = 0;
        for (int cyc = 0; cyc < 40 && g < 6; cyc++) begin
            step();
            if (req_ready != 2'b00) begin
                check($sformatf("t3_grant%0d", g), req_ready, (g % 2 == 1) ? 2'b10 : 2'b01);
                g++;
            end
        end
        req_valid = '0;
        check("t3_grant_count", g, 6);
        step();

        // r1 alone: back-to-back writes then a read
        set_req(1, 1'b1, 3'd0, 8'h10);
        for (int a = 0; a < 8; a++) begin
            step();
            check($sformatf("t4_ready%0d", a), req_ready, 2'b10);
            check($sformatf("t4_addr%0d", a), mem_addr, a);
            check($sformatf("t4_wdata%0d", a), mem_wdata, 8'h10 + a);
            if (a < 7) set_req(1, 1'b1, 3'(a + 1), 8'(8'h10 + a + 1));
            else       set_req(1, 1'b0, 3'd7, 8'h00);
            step();
            check($sformatf("t4_gap%0d", a), req_ready, 0);
        end
        step();
        check("t4_rd_ready", req_ready, 2'b10);
        check("t4_rd_we", mem_we, 0);
        req_valid[1] = 1'b0;
        step();
        step();
        check("t4_rsp_valid", rsp_valid, 2'b10);
        check("t4_rsp_rdata", rsp_rdata, 8'h17);

        // reset during READ of an r0 read
        set_req(0, 1'b0, 3'd7, 8'h00);
        step();
        check("t5_ready", req_ready, 2'b01);
        req_valid[0] = 1'b0;
        step();
        rst = 1'b1;
        step();
        check("t5_rsp_suppr", rsp_valid, 0);
        check("t5_en", mem_en, 0);
        rst = 1'b0;
        step();
        check("t5_rsp_still0", rsp_valid, 0);
        set_req(0, 1'b0, 3'd4, 8'h00);
        set_req(1, 1'b0, 3'd7, 8'h00);
        step();
        check("t5_tie_r0", req_ready, 2'b01);
        req_valid[0] = 1'b0;
        step();
        step();
        check("t5_rsp0_valid", rsp_valid, 2'b01);
        check("t5_rsp0_rdata", rsp_rdata, 8'h14);
        check("t5_rsp0_noready", req_ready, 0);
        step();
        check("t5_r1_ready", req_ready, 2'b10);
        req_valid[1] = 1'b0;
        step();
        step();
        check("t5_rsp1_valid", rsp_valid, 2'b10);
        check("t5_rsp1_rdata", rsp_rdata, 8'h17);

        // reset during ISSUE of a write: data still lands
        set_req(0, 1'b1, 3'd5, 8'hAA);
        step();
        check("t6_ready", req_ready, 2'b01);
        rst = 1'b1;
        req_valid = '0;
        step();
        check("t6_en", mem_en, 0);
        check("t6_ready_clr", req_ready, 0);
        check("t6_rsp", rsp_valid, 0);
        rst = 1'b0;
        step();
        set_req(0, 1'b0, 3'd5, 8'h00);
        step();
        check("t6_rd_ready", req_ready, 2'b01);
        req_valid[0] = 1'b0;
        step();
        step();
        check("t6_rsp_valid", rsp_valid, 2'b01);
        check("t6_rsp_rdata", rsp_rdata, 8'hAA);
        step();
        check("t6_rsp_pulse", rsp_valid, 0);
        check("t6_rdata_hold", rsp_rdata, 8'hAA);

        check("en_back_to_back", en_b2b, 0);
        check("ready_overlap", rdy_ovl, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
